sext_arbiter: RTL and testbench

//  Shares one sign/zero-extension datapath between two requesters: decode (req0, immediates)
//  and load unit (req1, byte/halfword load data). Round-robin arbitration, valid/ready on every

---
 rtl/sext_arbiter.sv | 148 ++++++++++++++
 tb/tb_sext_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/sext_arbiter.sv
// sext_arbiter: two requesters (decode, load unit) share one sign/zero
// extension datapath through a round-robin arbiter. A single registered
// output stage gives 1-cycle latency at full throughput.
// Parameters: N output width, M max input width (N > M, M >= 8).
// Optional feature macro: SEXT_ARB_STATS_EN adds saturating 16-bit
// per-requester transfer counters (grant0_cnt, grant1_cnt).
module sext_arbiter #(
   parameter int N = 32,
   parameter int M = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [M-1:0] req0_data,
   input  logic [1:0]   req0_mode,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [M-1:0] req1_data,
   input  logic [1:0]   req1_mode,
   output logic         req1_ready,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data,
   output logic         out_id
`ifdef SEXT_ARB_STATS_EN
   ,
   output logic [15:0]  grant0_cnt,
   output logic [15:0]  grant1_cnt
`endif
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      MODE_SIGN_M = 2'b00,
      MODE_ZERO_M = 2'b01,
      MODE_SIGN_8 = 2'b10,
      MODE_ZERO_8 = 2'b11
   } ext_mode_t;

   state_t         state;
   logic           last_grant;
   logic           can_accept;
   logic           grant0;
   logic           grant1;
   logic           xfer;
   logic           sel_id;
   logic [M-1:0]   sel_data;
   logic [1:0]     sel_mode;
   logic [N-1:0]   ext_data;

   // Extend an operand to N bits; upper input bits are ignored in byte modes.
   function automatic logic [N-1:0] extend(input logic [M-1:0] d, input logic [1:0] mode);
      logic [N-1:0] r;
      case (ext_mode_t'(mode))
         MODE_SIGN_M: r = {{(N-M){d[M-1]}}, d};
         MODE_ZERO_M: r = {{(N-M){1'b0}}, d};
         MODE_SIGN_8: r = {{(N-8){d[7]}}, d[7:0]};
         default:     r = {{(N-8){1'b0}}, d[7:0]};
      endcase
      return r;
   endfunction

   // Arbitration, handshake and operand select; ready depends on valid and
   // out_ready only, never on anything downstream of a requester's valid.
   always_comb begin
      // NOTE: every output of this block is given a default first so no
      // path leaves a signal unassigned and no latch is inferred.
      grant0     = 1'b0;
      grant1     = 1'b0;
      can_accept = (state == EMPTY) || out_ready;
      if (req0_valid && req1_valid) begin
         grant0 = last_grant;
         grant1 = !last_grant;
      end else begin
         grant0 = req0_valid;
         grant1 = req1_valid;
      end
      req0_ready = can_accept && grant0;
      req1_ready = can_accept && grant1;
      xfer       = req0_ready || req1_ready;
      sel_id     = grant1;
      sel_data   = grant1 ? req1_data : req0_data;
      sel_mode   = grant1 ? req1_mode : req0_mode;
      ext_data   = extend(sel_data, sel_mode);
   end

   // Output-stage FSM: EMPTY/FULL with registered valid, data, id and grant history.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (rst) begin
         // NOTE: out_data is reset too because its post-reset value is
         // observable; a pure pipeline data register would not need it.
         state      <= EMPTY;
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_id     <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (xfer) begin
                  state      <= FULL;
                  out_valid  <= 1'b1;
                  out_data   <= ext_data;
                  out_id     <= sel_id;
                  last_grant <= sel_id;
               end
            end
            FULL: begin
               if (xfer) begin
                  // Back-to-back: consumer takes the old result, new one loads.
                  out_data   <= ext_data;
                  out_id     <= sel_id;
                  last_grant <= sel_id;
               end else if (out_ready) begin
                  state      <= EMPTY;
                  out_valid  <= 1'b0;
               end
            end
            default: begin
               state     <= EMPTY;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

`ifdef SEXT_ARB_STATS_EN
   // Per-requester transfer counters, saturating at all-ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         grant0_cnt <= '0;
         grant1_cnt <= '0;
      end else begin
         if (req0_valid && req0_ready && (grant0_cnt != 16'hFFFF))
            grant0_cnt <= grant0_cnt + 16'd1;
         if (req1_valid && req1_ready && (grant1_cnt != 16'hFFFF))
            grant1_cnt <= grant1_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_sext_arbiter.sv
// Self-checking bench for sext_arbiter: a reference model predicts grants,
// readies and extended results; results are queued on transfer and compared
// while the output stage holds them. Honors SEXT_ARB_STATS_EN when defined.
module tb_sext_arbiter;

   localparam int N = 32;
   localparam int M = 16;

   typedef struct packed {
      logic [31:0] data;
      logic        id;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         req0_valid, req1_valid;
   logic [M-1:0] req0_data, req1_data;
   logic [1:0]   req0_mode, req1_mode;
   logic         req0_ready, req1_ready;
   logic         out_valid, out_ready;
   logic [N-1:0] out_data;
   logic         out_id;
`ifdef SEXT_ARB_STATS_EN
   logic [15:0]  grant0_cnt, grant1_cnt;
`endif

   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   logic mdl_full = 1'b0;
   logic mdl_last = 1'b1;
   int   mdl_cnt0 = 0;
   int   mdl_cnt1 = 0;

   always #5 clk = ~clk;

   sext_arbiter #(.N(N), .M(M)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_mode  (req0_mode),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_mode  (req1_mode),
      .req1_ready (req1_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .out_id     (out_id)
`ifdef SEXT_ARB_STATS_EN
      ,
      .grant0_cnt (grant0_cnt),
      .grant1_cnt (grant1_cnt)
`endif
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] ext_model(input logic [15:0] d, input logic [1:0] m);
      logic [7:0] b;
      b = d[7:0];
      case (m)
         2'b00:   return 32'($signed(d));
         2'b01:   return {16'h0000, d};
         2'b10:   return 32'($signed(b));
         default: return {24'h000000, b};
      endcase
   endfunction

   // One clock: drive at posedge+1, check at negedge, advance to next posedge+1.
   task automatic step(input logic r,
                       input logic v0, input logic [15:0] d0, input logic [1:0] m0,
                       input logic v1, input logic [15:0] d1, input logic [1:0] m1,
                       input logic ordy);
      logic g0, g1, acc;
      rst = r;
      req0_valid = v0; req0_data = d0; req0_mode = m0;
      req1_valid = v1; req1_data = d1; req1_mode = m1;
      out_ready = ordy;
      @(negedge clk);
      g0  = v0 && (!v1 || mdl_last);
      g1  = v1 && (!v0 || !mdl_last);
      acc = !mdl_full || ordy;
      check("req0_ready", 32'(req0_ready), 32'(acc && g0));
      check("req1_ready", 32'(req1_ready), 32'(acc && g1));
      if (!r) begin
         check("out_valid", 32'(out_valid), 32'(mdl_full));
         if (mdl_full) begin
            if (q.size() == 0) begin
               check("scoreboard_empty", 32'(q.size()), 32'd1);
            end else begin
               check("out_data", out_data, q[0].data);
               check("out_id", 32'(out_id), 32'(q[0].id));
               if (ordy) void'(q.pop_front());
            end
         end
         if (acc && (g0 || g1)) begin
            q.push_back('{data: ext_model(g1 ? d1 : d0, g1 ? m1 : m0), id: g1});
            mdl_last = g1;
            mdl_full = 1'b1;
            if (g1) mdl_cnt1++; else mdl_cnt0++;
         end else if (ordy) begin
            mdl_full = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      if (r) begin
         mdl_full = 1'b0;
         mdl_last = 1'b1;
         mdl_cnt0 = 0;
         mdl_cnt1 = 0;
         q.delete();
         check("rst_out_valid", 32'(out_valid), 32'd0);
         check("rst_out_data", out_data, 32'd0);
         check("rst_out_id", 32'(out_id), 32'd0);
`ifdef SEXT_ARB_STATS_EN
         check("rst_cnt0", 32'(grant0_cnt), 32'd0);
         check("rst_cnt1", 32'(grant1_cnt), 32'd0);
`endif
      end
   endtask

   task automatic idle(input logic ordy);
      step(1'b0, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, ordy);
   endtask

   initial begin
      rst = 1'b1;
      req0_valid = 1'b0; req0_data = '0; req0_mode = '0;
      req1_valid = 1'b0; req1_data = '0; req1_mode = '0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;

      // Reset held two cycles.
      step(1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b0);
      step(1'b1, 1'b0, 16'h0, 2'b00, 1'b0, 16'h0, 2'b00, 1'b0);

      // req0 alone, sign-M.
      step(1'b0, 1'b1, 16'h8001, 2'b00, 1'b0, 16'h0, 2'b00, 1'b1);
      check("t2_data", out_data, 32'hFFFF8001);
      check("t2_id", 32'(out_id), 32'd0);
      idle(1'b1);

      // req1 alone, back-to-back through sign-8, zero-8, zero-M.
      step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 16'h12F0, 2'b10, 1'b1);
      check("t3_sign8", out_data, 32'hFFFFFFF0);
      step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 16'h12F0, 2'b11, 1'b1);
      check("t3_zero8", out_data, 32'h000000F0);
      step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 16'h8001, 2'b01, 1'b1);
      check("t3_zeroM", out_data, 32'h00008001);
      idle(1'b1);

      // Both valid four cycles: alternate 0,1,0,1.
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, 16'hA000 + 16'(i), 2'(i), 1'b1, 16'h0085 + 16'(i), 2'(3 - i), 1'b1);
         check("t4_id_seq", 32'(out_id), 32'(i % 2));
      end
      idle(1'b1);

      // Backpressure: fill, stall three cycles with both valid, then release.
      step(1'b0, 1'b1, 16'h7F80, 2'b10, 1'b0, 16'h0, 2'b00, 1'b1);
      for (int i = 0; i < 3; i++)
         step(1'b0, 1'b1, 16'h1111, 2'b00, 1'b1, 16'hFF7F, 2'b00, 1'b0);
      step(1'b0, 1'b1, 16'h1111, 2'b00, 1'b1, 16'hFF7F, 2'b00, 1'b1);
      check("t5_release_id", 32'(out_id), 32'd1);
      check("t5_release_data", out_data, 32'hFFFFFF7F);
      idle(1'b1);

      // Randomized traffic against the model.
      for (int i = 0; i < 60; i++) begin
         step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 16'($urandom), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 3) != 0));
      end
`ifdef SEXT_ARB_STATS_EN
      check("cnt0", 32'(grant0_cnt), 32'(mdl_cnt0));
      check("cnt1", 32'(grant1_cnt), 32'(mdl_cnt1));
`endif

      // Reset while FULL with req1 valid, then req0 must win the first tie.
      step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 16'h4321, 2'b01, 1'b0);
      step(1'b0, 1'b0, 16'h0, 2'b00, 1'b1, 16'h4321, 2'b01, 1'b0);
      step(1'b1, 1'b0, 16'h0, 2'b00, 1'b1, 16'h4321, 2'b01, 1'b0);
      step(1'b0, 1'b1, 16'h00C3, 2'b11, 1'b1, 16'h4321, 2'b01, 1'b1);
      check("t6_tie_id", 32'(out_id), 32'd0);
      check("t6_tie_data", out_data, 32'h000000C3);
      idle(1'b1);
      idle(1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
